// File: rtl/mul_unit_iter.sv
// mul_unit_iter: iterative shift-add multiplier for the EX stage.
// Handles RV64M MUL, MULH, MULHSU and MULHU. Each CALC cycle consumes
// BITS_PER_CYCLE multiplier bits. Operands are reduced to magnitudes on
// entry, and the sign is applied once in FIX.
// Optional build macro: MUL_EARLY_TERMINATE_EN. When defined, CALC ends as
// soon as the remaining multiplier bits are all zero.
module mul_unit_iter #(
  parameter int DATA_W         = 64,
  parameter int BITS_PER_CYCLE = 4,
  parameter int REG_ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     rs1_data,
  input  logic [DATA_W-1:0]     rs2_data,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  busy
);

  localparam int N      = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int LOG_B  = $clog2(BITS_PER_CYCLE);
  localparam int SH_W   = $clog2(2 * DATA_W);
  localparam int ACC_W  = 2 * DATA_W;
  localparam int PROD_W = DATA_W + BITS_PER_CYCLE;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_W-1:0]       mcand_q, mcand_d;
  logic [DATA_W-1:0]       mplier_q, mplier_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    neg_q, neg_d;
  logic                    hi_q, hi_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic [REG_ADDR_W-1:0]   rd_out_q, rd_out_d;

  // Operand preparation signals (combinational from the input bus)
  logic                    rs1_signed, rs2_signed;
  logic                    rs1_neg, rs2_neg;
  logic [DATA_W-1:0]       rs1_mag, rs2_mag;

  // Datapath signals
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [PROD_W-1:0]         mcand_ext, digit_ext, prod;
  logic [SH_W-1:0]           shamt;
  logic [ACC_W-1:0]          pp;
  logic [ACC_W-1:0]          acc_sum;
  logic [DATA_W-1:0]         mplier_shift;
  logic [ACC_W-1:0]          acc_fix;
  logic [DATA_W-1:0]         fix_sel;
  logic                      calc_last;

  // Sign classification and magnitude extraction of incoming operands.
  // Negating in DATA_W bits is exact for the most-negative value too:
  // -0x8000... wraps to 0x8000..., which is its magnitude read as unsigned.
  always_comb begin
    rs1_signed = (op == OP_MULH) || (op == OP_MULHSU);
    rs2_signed = (op == OP_MULH);
    rs1_neg    = rs1_signed && rs1_data[DATA_W-1];
    rs2_neg    = rs2_signed && rs2_data[DATA_W-1];
    rs1_mag    = rs1_neg ? (~rs1_data + DATA_W'(1)) : rs1_data;
    rs2_mag    = rs2_neg ? (~rs2_data + DATA_W'(1)) : rs2_data;
  end

  // Shift-add datapath: one multiplier digit times the multiplicand,
  // placed at the digit's weight and added into the accumulator.
  always_comb begin
    digit        = mplier_q[BITS_PER_CYCLE-1:0];
    mcand_ext    = {{BITS_PER_CYCLE{1'b0}}, mcand_q};
    digit_ext    = {{DATA_W{1'b0}}, digit};
    prod         = mcand_ext * digit_ext;
    shamt        = SH_W'(count_q) << LOG_B;
    pp           = {{(ACC_W-PROD_W){1'b0}}, prod} << shamt;
    acc_sum      = acc_q + pp;
    mplier_shift = mplier_q >> BITS_PER_CYCLE;
    acc_fix      = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
    fix_sel      = hi_q ? acc_fix[ACC_W-1:DATA_W] : acc_fix[DATA_W-1:0];
  end

  // Decide whether the current CALC cycle is the final one
  always_comb begin
    calc_last = (count_q == LAST_CNT);
`ifdef MUL_EARLY_TERMINATE_EN
    if (mplier_shift == '0) begin
      calc_last = 1'b1;
    end
`endif
  end

  // Next-state and register-update logic; flush overrides everything
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    if (flush) begin
      state_d = IDLE;
    end else if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_d  = rs1_mag;
            mplier_d = rs2_mag;
            neg_d    = rs1_neg ^ rs2_neg;
            hi_d     = (op != OP_MUL);
            rd_d     = rd_in;
            acc_d    = '0;
            count_d  = '0;
            state_d  = CALC;
          end
        end
        CALC: begin
          acc_d    = acc_sum;
          mplier_d = mplier_shift;
          count_d  = count_q + CNT_W'(1);
          if (calc_last) begin
            state_d = FIX;
          end
        end
        FIX: begin
          result_d = fix_sel;
          rd_out_d = rd_q;
          state_d  = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // Status outputs decode directly from the state register
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    result    = result_q;
    rd_out    = rd_out_q;
  end

endmodule
